fetch_unit: RTL and testbench

- Instruction Fetch stage of the SimpleRISC pipeline.
- Sits at the far end of the Execute stage's branch interface. It consumes `isBranchTaken`/`branchPC` and redirects the PC.
- Owns the PC register, drives the instruction-memory request handshake, and holds the IF/OF pipeline register (`if_pc`, `if_instr`, `if_valid`) read by Operand Fetch.
- Handles wait-state memory, downstream stalls, and branch flushes, including branches that arrive while a fetch is outstanding.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction Fetch stage: owns the PC, runs the imem request handshake and
// holds the IF/OF pipeline register, with stall, hold and branch-flush handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic [31:0] redirect_q, redirect_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic [31:0] pc_next;

    assign pc_next   = pc_q + 32'(PC_STEP);
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        redirect_d = redirect_q;
        if_valid_d = stall ? if_valid_q : 1'b0;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        hold_d     = hold_q;
        hold_pc_d  = hold_pc_q;

        unique case (state_q)
            S_RESET: state_d = S_REQ;

            S_REQ: begin
                if (isBranchTaken) begin
                    if (imem_ready) begin
                        pc_d     = branchPC;
                        squash_d = 1'b0;
                    end else begin
                        // Keep the address stable; redirect once the stale response lands.
                        squash_d   = 1'b1;
                        redirect_d = branchPC;
                    end
                end else if (imem_ready) begin
                    if (squash_q) begin
                        pc_d     = redirect_q;
                        squash_d = 1'b0;
                    end else if (!if_valid_q || !stall) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_next;
                    end else begin
                        hold_d    = imem_rdata;
                        hold_pc_d = pc_q;
                        pc_d      = pc_next;
                        state_d   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (isBranchTaken) begin
                    pc_d    = branchPC;
                    state_d = S_REQ;
                end else if (!stall) begin
                    if_instr_d = hold_q;
                    if_pc_d    = hold_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = S_REQ;
                end
            end

            default: state_d = S_RESET;
        endcase

        // Flush beats stall and any load computed above.
        if (isBranchTaken) if_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            squash_q   <= 1'b0;
            redirect_q <= 32'h0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= 32'h0;
            hold_q     <= 32'h0;
            hold_pc_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            redirect_q <= redirect_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            hold_q     <= hold_d;
            hold_pc_q  <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then random stall/wait/branch traffic
// checked against a program-order model of the delivered PC stream.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        isBranchTaken = 1'b0;
    logic [31:0] branchPC = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .isBranchTaken(isBranchTaken), .branchPC(branchPC), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc = 32'h0;   // next PC the OF stage should receive
    int          idle = 0;
    int          max_idle = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    logic        prev_br = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check protocol and program order, then advance
    // to the next falling edge.
    task automatic cycle(input logic br, input logic [31:0] bpc,
                         input logic st, input logic rdy);
        isBranchTaken = br;
        branchPC      = bpc;
        stall         = st;
        imem_ready    = rdy;
        #1;
        if (pend) begin
            chk("addr_stable_req", {31'h0, imem_req}, 32'h1);
            chk("addr_stable", imem_addr, pend_addr);
        end
        if (if_valid && !st && !br) begin
            chk("if_pc_order", if_pc, exp_pc);
            chk("if_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            idle = 0;
        end else begin
            idle++;
        end
        if (idle > max_idle) max_idle = idle;
        if (br) exp_pc = bpc;
        pend      = imem_req && !rdy;
        pend_addr = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        br, st, rdy;
        logic [31:0] bpc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        rst_n = 1'b1;

        // Zero-wait stream: valid rises at edge 2
        cycle(0, 0, 0, 1);
        chk("lat_e1_valid", {31'h0, if_valid}, 32'h0);
        chk("lat_e1_req", {31'h0, imem_req}, 32'h1);
        chk("lat_e1_addr", imem_addr, 32'h0);
        cycle(0, 0, 0, 1);
        chk("lat_e2_valid", {31'h0, if_valid}, 32'h1);
        chk("lat_e2_pc", if_pc, 32'h0);
        cycle(0, 0, 0, 1);
        chk("seq_pc4", if_pc, 32'h4);
        cycle(0, 0, 0, 1);
        chk("seq_pc8", if_pc, 32'h8);

        // Stall three cycles at if_pc=8 -> hold state
        cycle(0, 0, 1, 1);
        chk("stall_pc", if_pc, 32'h8);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 1);
        chk("stall_pc3", if_pc, 32'h8);
        cycle(0, 0, 0, 1);
        chk("unstall_pcC", if_pc, 32'hC);
        cycle(0, 0, 0, 1);
        chk("unstall_pc10", if_pc, 32'h10);

        // Branch with ready memory
        cycle(1, 32'h100, 0, 1);
        chk("br_flush", {31'h0, if_valid}, 32'h0);
        chk("br_addr", imem_addr, 32'h100);
        cycle(0, 0, 0, 1);
        chk("br_tgt", if_pc, 32'h100);
        cycle(0, 0, 0, 1);
        chk("br_tgt4", if_pc, 32'h104);

        // Branch during a three-wait fetch
        cycle(1, 32'h40, 0, 0);
        chk("wait_addr1", imem_addr, 32'h108);
        chk("wait_flush", {31'h0, if_valid}, 32'h0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("wait_addr3", imem_addr, 32'h108);
        cycle(0, 0, 0, 1);
        chk("squash_drop", {31'h0, if_valid}, 32'h0);
        chk("squash_addr", imem_addr, 32'h40);
        cycle(0, 0, 0, 1);
        chk("squash_tgt", if_pc, 32'h40);
        chk("squash_valid", {31'h0, if_valid}, 32'h1);

        // Branch while holding under stall
        cycle(0, 0, 1, 1);
        chk("hold2_req", {31'h0, imem_req}, 32'h0);
        cycle(1, 32'h80, 1, 0);
        chk("holdbr_valid", {31'h0, if_valid}, 32'h0);
        chk("holdbr_addr", imem_addr, 32'h80);
        cycle(0, 0, 0, 1);
        chk("holdbr_tgt", if_pc, 32'h80);

        // PC wrap at top of address space
        cycle(1, 32'hFFFF_FFF8, 0, 1);
        cycle(0, 0, 0, 1);
        chk("wrap_f8", if_pc, 32'hFFFF_FFF8);
        cycle(0, 0, 0, 1);
        chk("wrap_fc", if_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1);
        chk("wrap_0", if_pc, 32'h0);

        // Async reset mid-request
        cycle(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, 32'h0);
        pend   = 1'b0;
        exp_pc = 32'h0;
        idle   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("arst_restart", if_pc, 32'h0);
        chk("arst_restart_v", {31'h0, if_valid}, 32'h1);

        // Random traffic against the program-order model
        for (int i = 0; i < 3000; i++) begin
            br  = !prev_br && ($urandom_range(0, 99) < 4);
            bpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) bpc = bpc | 32'hFFFF_FFF0;
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            prev_br = br;
            cycle(br, bpc, st, rdy);
        end
        cycle(0, 0, 0, 1);
        chk("progress_bound", {31'h0, (max_idle < 100)}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
